seg_code_capture: RTL and testbench
===================================

# seg_code_capture

Reverse path of the seven-segment display decoder. It samples a multiplexed, active-low segment bus (segments GFEDCBA plus active-low digit anodes), filters it for stability, and maps each stable pattern back to its 4-bit code. The recovered code is presented on a valid/ready output and stored in a per-digit frame register. It sits on the board-test side of the display path, closing the loop for self-check of the display driver.

## Interface
- `NDIG`, 4: number of multiplexed digits (anode width); 1..8.
- `STABLE_CYCLES`, 4: consecutive identical samples required before capture; 2..255.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `seg` input 7: segment lines, active-low, bit 6 = G … bit 0 = A; asynchronous to `clk`.
- `an` input `NDIG`: digit enables, active-low; asynchronous.
- `out_ready` input 1: consumer accepts the output word.
- `out_valid` output 1: capture word valid.
- `out_digit` output 3: index of the low anode bit for this capture.
- `out_code` output 4: recovered code.
- `out_err` output 1: pattern not in the code table; `out_code` = 0.
- `overrun` output 1: sticky; a capture was dropped.
- `frame_codes` output 4*`NDIG`: last code per digit, digit i at [4i+3:4i].
- `frame_done` output 1: one-cycle pulse when every digit has been captured since the previous pulse.

## Operation
- Input path: `{an,seg}` passes through a 2-flop synchronizer (s1, s2). s2 is compared with its previous value `sp`.
  - Mismatch: `cnt` ← 0 and `done` ← 0.
  - Match: `cnt` increments, saturating at `STABLE_CYCLES`.
- Capture condition: `cnt` = `STABLE_CYCLES`−1, s2 = `sp`, `done` = 0, and exactly one `an` bit is low. On capture, `done` ← 1, so there is one capture per stable episode.
- If zero or more than one `an` bit is low: no capture and no error, but `done` is still set.
- Code map (segment pattern → code):
  - 1000000 → 0; 1111001 → 1; 0100100 → 2; 0110000 → 3; 0011001 → 4; 0010010 → 5; 0000010 → 6; 1111000 → 7; 0000000 → 8; 0010000 → 9.
  - Character patterns (see Configuration): 1000110 → A; 0001100 → B; 1000001 → E; 0101111 → F.
  - Aliases 'o' (code C) and 'g' (code D) share patterns with 0 and 9, so they always decode to 0 and 9.
  - 1111111 (blank) and every other pattern: `out_err` = 1, `out_code` = 0.
- Output handshake:
  - A transfer occurs when `out_valid` & `out_ready`.
  - `out_valid` and its word are held stable until the transfer.
  - Capture while `out_valid` & !`out_ready`: the new word is dropped and `overrun` ← 1. It clears only on reset.
  - Capture in the same cycle as a transfer: the new word loads and `out_valid` stays 1.
- Frame:
  - Every capture, including dropped and erroring ones, writes `out_code` to the `frame_codes` slot and sets bit `out_digit` in `mask`. Rewriting a slot before the frame completes overwrites it.
  - When `mask` becomes all-ones, `frame_done` pulses for 1 cycle and `mask` clears in the same cycle the pulse is driven.

## Timing
- All outputs registered.
- Reset values:
  - `out_valid`=0, `out_digit`=0, `out_code`=0, `out_err`=0, `overrun`=0, `frame_codes`=0, `frame_done`=0.
  - Internal: `cnt`=0, `done`=0, `mask`=0, s1/s2/`sp` = all-ones (idle bus).
- Latency: with inputs held, `out_valid` rises on the (`STABLE_CYCLES`+2)th rising edge counted from the edge on which s1 first samples the new value (6 edges at the default).
- `frame_done` rises on the same edge as the `frame_codes` update that completes the mask.
- Any input glitch shorter than `STABLE_CYCLES` synchronized samples produces no capture.
- Reset asserted mid-episode: immediate return to reset values. After release, the current bus is treated as a new episode.

## Configuration
- `SEG_CODE_CHAR_EN` defined: the four character patterns decode to codes A, B, E, F with `out_err`=0.
- Not defined: those four patterns give `out_err`=1, `out_code`=0.
- Numeric decoding and 0/9 aliasing are identical in both builds.

## Test plan
- Reset, `an`=1110, `seg`=0100100 held, `out_ready`=1 → `out_valid` pulses exactly once on edge 6 with digit 0, code 2, err 0. No second capture while held.
- `seg` toggles between 0110000 and 0000000 every 2 cycles → no capture. Then held at 0000000 → one capture, code 8.
- Digits 0..3 driven in turn with 1,2,3,4, each held 10 cycles → four captures, `frame_codes`=16'h4321, single `frame_done` pulse after the digit-3 capture.
- `out_ready`=0, two captures (codes 5, 7) → word stays code 5, `overrun`=1. Raise `out_ready` → code 5 transfers, `overrun` stays 1.
- `seg`=1000110: with the macro → code A, err 0. Without → code 0, err 1. `seg`=1111111 → err 1 in both builds. `seg`=1000000 → code 0.
- `rst_n` pulsed low during a stable episode at `cnt`=2 → all outputs return to reset values. Capture occurs 6 edges after release.

Source files
------------

// File: rtl/seg_code_capture.sv
// Recovers 4-bit codes from a multiplexed active-low seven-segment bus.
// Define SEG_CODE_CHAR_EN to also decode the A/B/E/F character patterns.
module seg_code_capture #(
  parameter int unsigned NDIG          = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [6:0]            seg_i,
  input  logic [NDIG-1:0]       an_i,
  input  logic                  out_ready_i,
  output logic                  out_valid_o,
  output logic [2:0]            out_digit_o,
  output logic [3:0]            out_code_o,
  output logic                  out_err_o,
  output logic                  overrun_o,
  output logic [4*NDIG-1:0]     frame_codes_o,
  output logic                  frame_done_o
);

  localparam int unsigned BusW      = NDIG + 7;
  localparam logic [7:0]  StableMax = 8'(STABLE_CYCLES);
  // Capture fires on the match that brings cnt to STABLE_CYCLES-1.
  localparam logic [7:0]  StableHit = 8'(STABLE_CYCLES - 2);

  logic [BusW-1:0]   s1_q, s2_q, sp_q;
  logic [7:0]        cnt_q, cnt_d;
  logic              done_q, done_d;

  logic              valid_q, valid_d;
  logic [2:0]        digit_q, digit_d;
  logic [3:0]        code_q, code_d;
  logic              err_q, err_d;
  logic              overrun_q, overrun_d;
  logic [4*NDIG-1:0] frame_q, frame_d;
  logic [NDIG-1:0]   mask_q, mask_d, mask_nxt;
  logic              fdone_q, fdone_d;

  logic              match, episode_hit, one_hot, cap;
  logic [NDIG-1:0]   an_low;
  logic [6:0]        seg_s;
  logic [3:0]        ones;
  logic [2:0]        idx;
  logic [4:0]        dec;

  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1000000: r = {1'b0, 4'h0};
      7'b1111001: r = {1'b0, 4'h1};
      7'b0100100: r = {1'b0, 4'h2};
      7'b0110000: r = {1'b0, 4'h3};
      7'b0011001: r = {1'b0, 4'h4};
      7'b0010010: r = {1'b0, 4'h5};
      7'b0000010: r = {1'b0, 4'h6};
      7'b1111000: r = {1'b0, 4'h7};
      7'b0000000: r = {1'b0, 4'h8};
      7'b0010000: r = {1'b0, 4'h9};
`ifdef SEG_CODE_CHAR_EN
      7'b1000110: r = {1'b0, 4'hA};
      7'b0001100: r = {1'b0, 4'hB};
      7'b1000001: r = {1'b0, 4'hE};
      7'b0101111: r = {1'b0, 4'hF};
`endif
      default:    r = {1'b1, 4'h0};
    endcase
    return r;
  endfunction

  assign an_low = ~s2_q[BusW-1:7];
  assign seg_s  = s2_q[6:0];
  assign match  = (s2_q == sp_q);
  assign dec    = decode(seg_s);

  always_comb begin
    ones = 4'd0;
    idx  = 3'd0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (an_low[i]) begin
        ones = ones + 4'd1;
        idx  = 3'(i);
      end
    end
  end

  assign one_hot     = (ones == 4'd1);
  assign episode_hit = match && (cnt_q == StableHit) && !done_q;
  assign cap         = episode_hit && one_hot;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (!match) begin
      cnt_d  = 8'd0;
      done_d = 1'b0;
    end else begin
      if (cnt_q < StableMax) cnt_d = cnt_q + 8'd1;
      // An invalid anode pattern still consumes the episode.
      if (episode_hit) done_d = 1'b1;
    end
  end

  always_comb begin
    valid_d   = valid_q;
    digit_d   = digit_q;
    code_d    = code_q;
    err_d     = err_q;
    overrun_d = overrun_q;
    frame_d   = frame_q;
    mask_d    = mask_q;
    mask_nxt  = mask_q | an_low;
    fdone_d   = 1'b0;

    if (valid_q && out_ready_i) valid_d = 1'b0;

    if (cap) begin
      if (!valid_q || out_ready_i) begin
        valid_d = 1'b1;
        digit_d = idx;
        code_d  = dec[3:0];
        err_d   = dec[4];
      end else begin
        overrun_d = 1'b1;
      end
      // Frame tracking sees every capture, dropped ones included.
      for (int unsigned i = 0; i < NDIG; i++) begin
        if (an_low[i]) frame_d[4*i +: 4] = dec[3:0];
      end
      if (&mask_nxt) begin
        fdone_d = 1'b1;
        mask_d  = '0;
      end else begin
        mask_d  = mask_nxt;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q      <= '1;
      s2_q      <= '1;
      sp_q      <= '1;
      cnt_q     <= 8'd0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      digit_q   <= 3'd0;
      code_q    <= 4'd0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
      frame_q   <= '0;
      mask_q    <= '0;
      fdone_q   <= 1'b0;
    end else begin
      s1_q      <= {an_i, seg_i};
      s2_q      <= s1_q;
      sp_q      <= s2_q;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      digit_q   <= digit_d;
      code_q    <= code_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
      frame_q   <= frame_d;
      mask_q    <= mask_d;
      fdone_q   <= fdone_d;
    end
  end

  assign out_valid_o   = valid_q;
  assign out_digit_o   = digit_q;
  assign out_code_o    = code_q;
  assign out_err_o     = err_q;
  assign overrun_o     = overrun_q;
  assign frame_codes_o = frame_q;
  assign frame_done_o  = fdone_q;

endmodule

// File: tb/tb_seg_code_capture.sv
// Directed bench for seg_code_capture (default NDIG=4, STABLE_CYCLES=4).
module tb_seg_code_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        out_ready;
  logic        out_valid;
  logic [2:0]  out_digit;
  logic [3:0]  out_code;
  logic        out_err;
  logic        overrun;
  logic [15:0] frame_codes;
  logic        frame_done;

  int checks = 0;
  int passed = 0;

  seg_code_capture #(
    .NDIG         (4),
    .STABLE_CYCLES(4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .seg_i        (seg),
    .an_i         (an),
    .out_ready_i  (out_ready),
    .out_valid_o  (out_valid),
    .out_digit_o  (out_digit),
    .out_code_o   (out_code),
    .out_err_o    (out_err),
    .overrun_o    (overrun),
    .frame_codes_o(frame_codes),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    an        = 4'b1111;
    seg       = 7'b1111111;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  // Holds a bus value for n cycles and records what got transferred.
  task automatic hold_bus(input logic [3:0] a, input logic [6:0] s, input int n,
                          output int ncap, output logic [3:0] code, output logic err,
                          output logic [2:0] digit, output int nfd,
                          output logic [15:0] fc_at_fd);
    an = a;
    seg = s;
    ncap = 0;
    nfd = 0;
    code = 4'd0;
    err = 1'b0;
    digit = 3'd0;
    fc_at_fd = 16'h0;
    repeat (n) begin
      tick();
      if (out_valid && out_ready) begin
        ncap++;
        code  = out_code;
        err   = out_err;
        digit = out_digit;
      end
      if (frame_done) begin
        nfd++;
        fc_at_fd = frame_codes;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2;
    an = 4'b1111; seg = 7'b1111111; out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid); else passed++;
    checks++; if (out_digit !== 3'd0) $display("FAIL rst_digit got %0d want 0", out_digit); else passed++;
    checks++; if (out_code !== 4'd0) $display("FAIL rst_code got %0h want 0", out_code); else passed++;
    checks++; if (out_err !== 1'b0) $display("FAIL rst_err got %b want 0", out_err); else passed++;
    checks++; if (overrun !== 1'b0) $display("FAIL rst_overrun got %b want 0", overrun); else passed++;
    checks++; if (frame_codes !== 16'h0) $display("FAIL rst_frame got %h want 0", frame_codes); else passed++;
    checks++; if (frame_done !== 1'b0) $display("FAIL rst_fdone got %b want 0", frame_done); else passed++;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL idle_valid got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_latency;
    int extra;
    apply_reset();
    an = 4'b1110; seg = 7'b0100100; out_ready = 1'b1;
    extra = 0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 6) begin
        checks++; if (out_valid !== 1'b1) $display("FAIL lat_valid edge6 got %b want 1", out_valid); else passed++;
        checks++; if (out_digit !== 3'd0) $display("FAIL lat_digit got %0d want 0", out_digit); else passed++;
        checks++; if (out_code !== 4'd2) $display("FAIL lat_code got %0h want 2", out_code); else passed++;
        checks++; if (out_err !== 1'b0) $display("FAIL lat_err got %b want 0", out_err); else passed++;
      end else if (out_valid) begin
        extra++;
      end
    end
    checks++; if (extra != 0) $display("FAIL lat_extra got %0d want 0", extra); else passed++;
  endtask

  task automatic test_glitch;
    int ncap, nfd, gl;
    logic [3:0] code; logic err; logic [2:0] digit; logic [15:0] fc;
    out_ready = 1'b1;
    an = 4'b1110;
    gl = 0;
    for (int k = 0; k < 8; k++) begin
      seg = (k % 2 == 1) ? 7'b0000000 : 7'b0110000;
      repeat (2) begin
        tick();
        if (out_valid) gl++;
      end
    end
    checks++; if (gl != 0) $display("FAIL glitch_cap got %0d want 0", gl); else passed++;
    hold_bus(4'b1110, 7'b0000000, 12, ncap, code, err, digit, nfd, fc);
    checks++; if (ncap != 1) $display("FAIL glitch_hold_n got %0d want 1", ncap); else passed++;
    checks++; if (code !== 4'd8) $display("FAIL glitch_hold_code got %0h want 8", code); else passed++;
    hold_bus(4'b1100, 7'b1111001, 12, ncap, code, err, digit, nfd, fc);
    checks++; if (ncap != 0) $display("FAIL two_anodes_cap got %0d want 0", ncap); else passed++;
  endtask

  task automatic test_frame;
    int ncap, nfd;
    logic [3:0] code; logic err; logic [2:0] digit; logic [15:0] fc;
    logic [3:0]  an_v  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0]  seg_v [4] = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    apply_reset();
    for (int d = 0; d < 4; d++) begin
      hold_bus(an_v[d], seg_v[d], 10, ncap, code, err, digit, nfd, fc);
      checks++; if (ncap != 1 || code !== 4'(d + 1) || digit !== 3'(d))
        $display("FAIL frame_cap%0d got n=%0d code=%0h digit=%0d want n=1 code=%0d digit=%0d",
                 d, ncap, code, digit, d + 1, d);
      else passed++;
      checks++; if (nfd != ((d == 3) ? 1 : 0))
        $display("FAIL frame_done%0d got %0d want %0d", d, nfd, (d == 3) ? 1 : 0);
      else passed++;
      if (d == 3) begin
        checks++; if (fc !== 16'h4321) $display("FAIL frame_at_done got %h want 4321", fc); else passed++;
      end
    end
    checks++; if (frame_codes !== 16'h4321) $display("FAIL frame_codes got %h want 4321", frame_codes); else passed++;
    hold_bus(4'b1110, 7'b0010010, 10, ncap, code, err, digit, nfd, fc);
    checks++; if (nfd != 0) $display("FAIL frame_mask_clear got %0d want 0", nfd); else passed++;
    checks++; if (frame_codes !== 16'h4325) $display("FAIL frame_rewrite got %h want 4325", frame_codes); else passed++;
  endtask

  task automatic test_overrun;
    int ncap, nfd;
    logic [3:0] code; logic err; logic [2:0] digit; logic [15:0] fc;
    apply_reset();
    out_ready = 1'b0;
    hold_bus(4'b1110, 7'b0010010, 10, ncap, code, err, digit, nfd, fc);
    checks++; if (overrun !== 1'b0) $display("FAIL ovr_early got %b want 0", overrun); else passed++;
    hold_bus(4'b1110, 7'b1111000, 10, ncap, code, err, digit, nfd, fc);
    checks++; if (out_valid !== 1'b1) $display("FAIL ovr_valid got %b want 1", out_valid); else passed++;
    checks++; if (out_code !== 4'd5) $display("FAIL ovr_code got %0h want 5", out_code); else passed++;
    checks++; if (overrun !== 1'b1) $display("FAIL ovr_flag got %b want 1", overrun); else passed++;
    checks++; if (frame_codes[3:0] !== 4'd7) $display("FAIL ovr_frame got %0h want 7", frame_codes[3:0]); else passed++;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL ovr_xfer got %b want 0", out_valid); else passed++;
    checks++; if (overrun !== 1'b1) $display("FAIL ovr_sticky got %b want 1", overrun); else passed++;
  endtask

  task automatic test_chars;
    int ncap, nfd;
    logic [3:0] code; logic err; logic [2:0] digit; logic [15:0] fc;
    logic [6:0] pat  [5] = '{7'b1000110, 7'b1111111, 7'b1000000, 7'b0010000, 7'b0101111};
`ifdef SEG_CODE_CHAR_EN
    logic [3:0] ecode[5] = '{4'hA, 4'h0, 4'h0, 4'h9, 4'hF};
    logic       eerr [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`else
    logic [3:0] ecode[5] = '{4'h0, 4'h0, 4'h0, 4'h9, 4'h0};
    logic       eerr [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`endif
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      hold_bus(4'b1110, pat[k], 10, ncap, code, err, digit, nfd, fc);
      checks++; if (ncap != 1 || code !== ecode[k] || err !== eerr[k])
        $display("FAIL char%0d got n=%0d code=%0h err=%b want n=1 code=%0h err=%b",
                 k, ncap, code, err, ecode[k], eerr[k]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    int ncap, nfd, extra;
    logic [3:0] code; logic err; logic [2:0] digit; logic [15:0] fc;
    apply_reset();
    out_ready = 1'b0;
    hold_bus(4'b1101, 7'b0110000, 10, ncap, code, err, digit, nfd, fc);
    checks++; if (out_valid !== 1'b1 || out_digit !== 3'd1)
      $display("FAIL mid_pre got valid=%b digit=%0d want valid=1 digit=1", out_valid, out_digit);
    else passed++;
    an = 4'b1110; seg = 7'b0011001;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_code !== 4'd0 || out_digit !== 3'd0 || out_err !== 1'b0)
      $display("FAIL mid_rst_word got valid=%b code=%0h digit=%0d err=%b want all 0",
               out_valid, out_code, out_digit, out_err);
    else passed++;
    checks++; if (frame_codes !== 16'h0 || overrun !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL mid_rst_frame got frame=%h ovr=%b fd=%b want 0", frame_codes, overrun, frame_done);
    else passed++;
    rst_n = 1'b1;
    out_ready = 1'b1;
    extra = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 6) begin
        checks++; if (out_valid !== 1'b1 || out_code !== 4'd4 || out_digit !== 3'd0)
          $display("FAIL mid_cap got valid=%b code=%0h digit=%0d want 1/4/0",
                   out_valid, out_code, out_digit);
        else passed++;
      end else if (out_valid) begin
        extra++;
      end
    end
    checks++; if (extra != 0) $display("FAIL mid_extra got %0d want 0", extra); else passed++;
  endtask

  initial begin
    rst_n = 1'b1;
    an = 4'b1111;
    seg = 7'b1111111;
    out_ready = 1'b1;
    test_reset();
    test_latency();
    test_glitch();
    test_frame();
    test_overrun();
    test_chars();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
